// File: rtl/ha_stim_chk_pkg.sv
// ============================================================================
// Module      : ha_stim_chk_pkg
// Description : Shared types and helpers for the half-adder stimulus/checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ha_stim_chk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRIVE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int NUM_VEC = 4;

   // Golden half-adder response packed as {carry, sum}.
   function automatic logic [1:0] exp_rsp(input logic a, input logic b);
      return {a & b, a ^ b};
   endfunction

endpackage

`default_nettype wire

// File: rtl/ha_stim_chk_settle_cnt.sv
// ============================================================================
// Module      : ha_settle_cnt
// Description : Loadable down-counter with zero flag, times the settle window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ha_settle_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/ha_stim_chk.sv
// ============================================================================
// Module      : ha_stim_chk
// Description : Clocked stimulus/response engine for a half adder; sweeps all
//               four vectors and counts mismatches. Optional first-failure
//               capture enabled by HA_STIM_CHK_FAILCAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ha_stim_chk
   import ha_stim_chk_pkg::*;
#(
   parameter int SETTLE_CYC = 1,
   parameter int LOOPS      = 1,
   parameter int ERR_W      = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   input  logic             sum_i,
   input  logic             carry_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [1:0]       vec_idx,
   output logic [ERR_W-1:0] err_cnt
`ifdef HA_STIM_CHK_FAILCAP_EN
   ,
   output logic             fail_vld,
   output logic [1:0]       fail_idx,
   output logic [1:0]       fail_rsp
`endif
);

   localparam logic [1:0] LAST_VEC  = 2'(NUM_VEC - 1);
   localparam logic [7:0] LAST_LOOP = 8'(LOOPS - 1);
   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);

   state_e           state_q, state_d;
   logic [1:0]       vec_q, vec_d;
   logic [7:0]       loop_q, loop_d;
   logic             a_q, a_d;
   logic             b_q, b_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             mis_q, mis_d;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic             rsp_bad;
   logic [1:0]       vec_nxt;

   ha_settle_cnt #(
      .W (4)
   ) u_settle (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (SETTLE_LD),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   assign rsp_bad = ({carry_i, sum_i} != exp_rsp(a_q, b_q));
   assign vec_nxt = vec_q + 2'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         loop_q  <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         err_q   <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         loop_q  <= loop_d;
         a_q     <= a_d;
         b_q     <= b_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
      end
   end

   // a/b are loaded on the edge that enters DRIVE, so they hold through CHECK.
   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      loop_d   = loop_q;
      a_d      = a_q;
      b_d      = b_q;
      err_d    = err_q;
      mis_d    = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_DRIVE;
               vec_d   = '0;
               loop_d  = '0;
               a_d     = 1'b0;
               b_d     = 1'b0;
               err_d   = '0;
            end
         end
         ST_DRIVE: begin
            cnt_load = 1'b1;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_zero) begin
               state_d = ST_CHECK;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_CHECK: begin
            if (rsp_bad) begin
               mis_d = 1'b1;
               if (err_q != '1) begin
                  err_d = err_q + 1'b1;
               end
            end
            if (vec_q != LAST_VEC) begin
               vec_d   = vec_nxt;
               a_d     = vec_nxt[1];
               b_d     = vec_nxt[0];
               state_d = ST_DRIVE;
            end else if (loop_q < LAST_LOOP) begin
               loop_d  = loop_q + 8'd1;
               vec_d   = '0;
               a_d     = 1'b0;
               b_d     = 1'b0;
               state_d = ST_DRIVE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign a_o      = a_q;
   assign b_o      = b_q;
   assign vec_idx  = vec_q;
   assign err_cnt  = err_q;
   assign mismatch = mis_q;
   assign busy     = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
   assign done     = (state_q == ST_DONE);
   assign pass     = done && (err_q == '0);

`ifdef HA_STIM_CHK_FAILCAP_EN
   logic       fail_vld_q;
   logic [1:0] fail_idx_q;
   logic [1:0] fail_rsp_q;
   logic       run_clr;
   logic       fail_cap;

   assign run_clr  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
   assign fail_cap = (state_q == ST_CHECK) && rsp_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_vld_q <= 1'b0;
         fail_idx_q <= '0;
         fail_rsp_q <= '0;
      end else if (run_clr) begin
         fail_vld_q <= 1'b0;
         fail_idx_q <= '0;
         fail_rsp_q <= '0;
      end else if (fail_cap && !fail_vld_q) begin
         fail_vld_q <= 1'b1;
         fail_idx_q <= vec_q;
         fail_rsp_q <= {carry_i, sum_i};
      end
   end

   assign fail_vld = fail_vld_q;
   assign fail_idx = fail_idx_q;
   assign fail_rsp = fail_rsp_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ha_stim_chk.sv
// ============================================================================
// Module      : tb_ha_stim_chk
// Description : Self-checking bench for ha_stim_chk with a fault-injectable
//               half-adder model; expectations come from per-vector timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ha_stim_chk;

   localparam int S     = 3;
   localparam int L     = 2;
   localparam int EW    = 2;
   localparam int PER   = S + 2;
   localparam int NV    = 4 * L;
   localparam int TOTAL = NV * PER;
   localparam int SAT   = (1 << EW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          a_o, b_o, sum_i, carry_i;
   logic          busy, done, pass, mismatch;
   logic [1:0]    vec_idx;
   logic [EW-1:0] err_cnt;
`ifdef HA_STIM_CHK_FAILCAP_EN
   logic          fail_vld;
   logic [1:0]    fail_idx, fail_rsp;
`endif

   logic [7:0]    flips = 8'h00;
   logic [7:0]    sh;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   // Half adder with per-vector response flips ({carry,sum} XOR mask).
   always_comb begin
      sh = flips >> {a_o, b_o, 1'b0};
      {carry_i, sum_i} = {a_o & b_o, a_o ^ b_o} ^ sh[1:0];
   end

   ha_stim_chk #(
      .SETTLE_CYC (S),
      .LOOPS      (L),
      .ERR_W      (EW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a_o      (a_o),
      .b_o      (b_o),
      .sum_i    (sum_i),
      .carry_i  (carry_i),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .mismatch (mismatch),
      .vec_idx  (vec_idx),
      .err_cnt  (err_cnt)
`ifdef HA_STIM_CHK_FAILCAP_EN
      ,
      .fail_vld (fail_vld),
      .fail_idx (fail_idx),
      .fail_rsp (fail_rsp)
`endif
   );

   // One full run: start accepted at edge 0, then each edge checked against
   // the timing model (vector j driven from edge j*PER, verdict at (j+1)*PER).
   task automatic run_vectors(input logic [7:0] fm, input int repulse);
      logic [7+EW:0] got, exp;
      int            k, nerr, j, v, ecnt;
      logic          eb, ed, em;
      logic [1:0]    ev;
      logic [1:0]    fl;
      logic          first_seen;
      logic [1:0]    first_idx, first_rsp;
      flips = fm;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int n = 0; n <= TOTAL + 2; n++) begin
         if (n > 0) begin
            start = (n == repulse);
            @(posedge clk);
            #1;
            start = 1'b0;
         end
         k = (n / PER < NV) ? n / PER : NV;
         nerr = 0;
         for (int i = 0; i < k; i++) begin
            fl = fm[2*(i%4) +: 2];
            if (fl != 2'b00) nerr++;
         end
         ecnt = (nerr > SAT) ? SAT : nerr;
         em = 1'b0;
         if ((n % PER == 0) && (n > 0) && (n <= TOTAL)) begin
            fl = fm[2*((n/PER - 1) % 4) +: 2];
            em = (fl != 2'b00);
         end
         if (n < TOTAL) begin
            j  = n / PER;
            v  = j % 4;
            eb = 1'b1;
            ed = 1'b0;
         end else begin
            v  = 3;
            eb = 1'b0;
            ed = 1'b1;
         end
         ev  = 2'(v);
         exp = {eb, ed, ed && (ecnt == 0), em, ev, ev[1], ev[0], EW'(ecnt)};
         got = {busy, done, pass, mismatch, vec_idx, a_o, b_o, err_cnt};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL run cyc=%0d flips=%h busy/done/pass/mis/vec/a/b/err got=%b expected=%b",
                     n, fm, got, exp);
         end
      end
      first_seen = 1'b0;
      first_idx  = 2'b00;
      first_rsp  = 2'b00;
      for (int i = 3; i >= 0; i--) begin
         fl = fm[2*i +: 2];
         if (fl != 2'b00) begin
            first_seen = 1'b1;
            first_idx  = 2'(i);
            first_rsp  = {i[1] & i[0], i[1] ^ i[0]} ^ fl;
         end
      end
`ifdef HA_STIM_CHK_FAILCAP_EN
      checks++;
      if ({fail_vld, fail_idx, fail_rsp} !== {first_seen, first_idx, first_rsp}) begin
         errors++;
         $display("FAIL failcap flips=%h got vld/idx/rsp=%b expected=%b", fm,
                  {fail_vld, fail_idx, fail_rsp}, {first_seen, first_idx, first_rsp});
      end
`endif
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({busy, done, pass, mismatch, vec_idx, a_o, b_o, err_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_state got=%b expected 0",
                  {busy, done, pass, mismatch, vec_idx, a_o, b_o, err_cnt});
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, pass, mismatch, vec_idx, a_o, b_o, err_cnt} !== '0) begin
         errors++;
         $display("FAIL idle_hold got=%b expected 0",
                  {busy, done, pass, mismatch, vec_idx, a_o, b_o, err_cnt});
      end
   endtask

   task automatic test_directed();
      run_vectors(8'h00, -1);      // correct adder
      run_vectors(8'h80, -1);      // carry stuck at 0: only vector 3 fails
      run_vectors(8'h55, -1);      // sum inverted: every check fails, saturates
   endtask

   task automatic test_start_ignored();
      run_vectors(8'h00, 5);       // start while busy
      run_vectors(8'h04, TOTAL);   // start in the cycle DONE is entered
   endtask

   task automatic test_back_to_back();
      run_vectors(8'hFF, -1);
      run_vectors(8'h00, -1);      // restart from DONE clears err/pass/done
   endtask

   task automatic test_midrun_reset();
      flips = 8'hFF;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, pass, mismatch, vec_idx, a_o, b_o, err_cnt} !== '0) begin
         errors++;
         $display("FAIL async_reset got=%b expected 0",
                  {busy, done, pass, mismatch, vec_idx, a_o, b_o, err_cnt});
      end
`ifdef HA_STIM_CHK_FAILCAP_EN
      checks++;
      if ({fail_vld, fail_idx, fail_rsp} !== 5'b0) begin
         errors++;
         $display("FAIL async_reset_failcap got=%b expected 0", {fail_vld, fail_idx, fail_rsp});
      end
`endif
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, err_cnt} !== '0) begin
         errors++;
         $display("FAIL post_reset_idle got=%b expected 0", {busy, done, err_cnt});
      end
      run_vectors(8'h00, -1);
   endtask

   task automatic test_random();
      logic [7:0] fm;
      int         rp;
      for (int r = 0; r < 8; r++) begin
         fm = 8'($urandom);
         rp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, TOTAL)) : -1;
         run_vectors(fm, rp);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_ignored();
      test_back_to_back();
      test_midrun_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ha_stim_chk.md
Name: ha_stim_chk

Overview:
- Synthesizable stimulus/response end of the half-adder port bundle. It drives a/b and samples sum/carry, which is the role of the TB_P modport view.
- It sequences all four input vectors, waits a programmable settle time per vector, compares the response against expected, and counts mismatches.
- It sits beside the half-adder DUT inside a top wrapper. It turns the hand-written initial-block stimulus into a clocked, self-checking built-in-test engine.

Parameters:
- SETTLE_CYC, 1: cycles a/b are held stable before sum/carry are sampled; legal range 1..15.
- LOOPS, 1: number of full 4-vector sweeps per start; legal range 1..255.
- ERR_W, 3: width of the mismatch counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; ignored unless in IDLE or DONE.
- a_o  output  1  stimulus a, to the DUT a input.
- b_o  output  1  stimulus b, to the DUT b input.
- sum_i  input  1  DUT sum response.
- carry_i  input  1  DUT carry response.
- busy  output  1  high from the first DRIVE cycle until DONE is entered.
- done  output  1  level; high in DONE, cleared by the next accepted start.
- pass  output  1  equals done AND (err_cnt == 0).
- mismatch  output  1  one-cycle pulse, the cycle after a failing CHECK.
- vec_idx  output  2  index of the vector currently driven.
- err_cnt  output  ERR_W  saturating mismatch count for the current run.

Behaviour:
- Reset (async assert, sync release): state=IDLE; a_o, b_o, busy, done, pass, mismatch, vec_idx, err_cnt, loop counter and settle counter all 0.
- Vector mapping: a_o=vec_idx[1], b_o=vec_idx[0]. Expected sum=a^b, expected carry=a&b.
- FSM states are IDLE, DRIVE, WAIT, CHECK, DONE.
  - IDLE/DONE, start=1 -> DRIVE. This clears err_cnt, done and pass, and sets vec_idx=0 and loop=0.
  - DRIVE (1 cycle): a_o/b_o are registered from vec_idx; settle counter loads SETTLE_CYC-1. -> WAIT.
  - WAIT: counter decrements each cycle; leave when it is 0. -> CHECK. WAIT therefore lasts SETTLE_CYC cycles.
  - CHECK (1 cycle): compare {carry_i,sum_i} against expected.
    - On mismatch: err_cnt increments, saturating at 2^ERR_W-1, and mismatch pulses on the next cycle.
    - If vec_idx<3: vec_idx++ -> DRIVE.
    - Else if loop<LOOPS-1: loop++, vec_idx=0 -> DRIVE.
    - Else -> DONE.
  - DONE: done=1 and busy=0; the block holds its results until the next start.
- Timing: each vector costs SETTLE_CYC+2 cycles; a run costs 4*LOOPS*(SETTLE_CYC+2) cycles from the start cycle to the first DONE cycle.
- a_o/b_o are stable from DRIVE through CHECK and never change in WAIT or CHECK.
- start while busy is ignored, with no restart and no error.
- start in the same cycle DONE is entered is ignored.
- Reset mid-run aborts immediately to IDLE. There is no partial result and done stays 0.
- A mismatch in the same cycle err_cnt is saturated leaves err_cnt unchanged but still pulses mismatch.

Optional Feature:
- Macro: HA_STIM_CHK_FAILCAP_EN.
- Defined: adds outputs fail_vld (1), fail_idx (2) and fail_rsp (2, as {carry,sum}).
  - These capture the first failing vector of the run; later failures do not overwrite them.
  - All three are cleared on reset and on an accepted start.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package ha_stim_chk_pkg holds:
  - the state enum typedef (IDLE, DRIVE, WAIT, CHECK, DONE);
  - the constant NUM_VEC=4;
  - the function exp_rsp(a,b), returning {a&b, a^b}.
- One natural sub-module, ha_settle_cnt: a loadable down-counter with load, dec and zero flag. It is instantiated for the WAIT timing.

Test Plan:
- Correct DUT, SETTLE_CYC=1, LOOPS=1, start pulsed at cycle 0.
  - Response: a/b sequence 00,01,10,11, each held 3 cycles.
  - done rises at cycle 12 with pass=1 and err_cnt=0.
- DUT with carry stuck-at-0:
  - One mismatch at vec_idx=3, so err_cnt=1 and pass=0.
  - With HA_STIM_CHK_FAILCAP_EN defined: fail_idx=3 and fail_rsp=2'b00.
- DUT with sum inverted, ERR_W=2, LOOPS=2:
  - 8 failures; err_cnt saturates at 3.
  - mismatch pulses 8 times.
- start re-pulsed at cycle 5 of a run:
  - The run is unaffected and done still rises at cycle 12.
  - A second start in DONE restarts the run, clearing done, pass and err_cnt.
- rst asserted at cycle 7 mid-run:
  - All outputs go to 0 asynchronously and the state is IDLE.
  - A start after release completes a full run normally.
- SETTLE_CYC=4, LOOPS=3:
  - Each vector is held 6 cycles and done arrives at cycle 72.
  - a_o/b_o never toggle outside DRIVE.
